surf_cmd_decode: RTL and testbench

SURF-side receiver for the 32-bit rackbus command word built by the TURFIO command splicer. It tracks the 8-cycle command phase, captures one word per frame and unpacks it into independent mode1, runcmd and trigger AXI4-Stream outputs plus a PPS pulse. It sits between the SURF command deserializer and the SURF firmware-update, run-control and trigger logic.

---
 rtl/surf_cmd_decode.sv | 152 +++++++++++++++
 tb/tb_surf_cmd_decode.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/surf_cmd_decode.sv
// surf_cmd_decode: SURF-side rackbus command word receiver.
// Tracks the 8-cycle command phase, captures one word per frame and
// unpacks it into mode1 / runcmd / trig AXI4-Stream holding registers
// plus a one-cycle PPS pulse. Misaligned strobes drop lock and are counted.

// Single-entry stream holding register. A load that finds the slot
// occupied and not draining this cycle is dropped and flagged.
module surf_cmd_hold #(
  parameter int W = 8
) (
  input  logic         sysclk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         tready_i,
  output logic         tvalid_o,
  output logic [W-1:0] tdata_o,
  output logic         ovf_o
);
  logic         valid_q;
  logic [W-1:0] data_q;
  logic         blocked;

  // Slot stays busy this cycle only if it holds data and no handshake occurs.
  assign blocked = valid_q && !tready_i;
  assign ovf_o   = load_i && blocked;

  // Load frees/refills the slot; a handshake without a load empties it.
  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i && !blocked) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (valid_q && tready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign tvalid_o = valid_q;
  assign tdata_o  = data_q;
endmodule

module surf_cmd_decode #(
  parameter int RUNCMD_BITS = 2,
  parameter int TRIG_BITS   = 15
) (
  input  logic                   sysclk_i,
  input  logic                   rst_i,
  input  logic                   sync_i,
  input  logic [31:0]            command_i,
  input  logic                   command_valid_i,
  output logic [7:0]             mode1_tdata,
  output logic [1:0]             mode1_tuser,
  output logic                   mode1_tvalid,
  input  logic                   mode1_tready,
  output logic [RUNCMD_BITS-1:0] runcmd_tdata,
  output logic                   runcmd_tvalid,
  input  logic                   runcmd_tready,
  output logic [TRIG_BITS-1:0]   trig_tdata,
  output logic                   trig_tvalid,
  input  logic                   trig_tready,
  output logic                   pps_o,
  output logic                   locked_o,
  output logic [2:0]             overflow_o,
  output logic [15:0]            err_count_o,
  input  logic                   clear_i
);
  logic [2:0]  phase_q;
  logic [2:0]  phase_cur;
  logic        locked_q, locked_d;
  logic        pps_q;
  logic [2:0]  ovf_q, ovf_d;
  logic [15:0] err_q, err_d;
  logic        misalign, capture, ignore;
  logic        load_m1, load_rc, load_tr;
  logic [2:0]  ovf_set;
  logic [9:0]  m1_word;
  logic        unused_rsvd;

  // The sync cycle itself is phase 0, regardless of the counter.
  assign phase_cur = sync_i ? 3'd0 : phase_q;
  assign misalign  = command_valid_i && (phase_cur != 3'd7);
  assign capture   = command_valid_i && (phase_cur == 3'd7) && locked_q;
  assign ignore    = command_i[31];

  // NOOP mode1 is type 0 with data 0; anything else is a real byte.
  assign load_m1 = capture && !ignore && (command_i[27:18] != 10'd0);
  assign load_rc = capture && !ignore && (command_i[28 +: RUNCMD_BITS] != '0);
  assign load_tr = capture && !ignore && command_i[15];

  // Reserved bits are intentionally discarded.
  assign unused_rsvd = ^command_i[17:16];

  // Frame phase: sync loads 1 so the following cycle is phase 1.
  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) phase_q <= 3'd0;
    else       phase_q <= sync_i ? 3'd1 : phase_q + 3'd1;
  end

  // Sync wins over a same-cycle misaligned strobe; the error still counts.
  always_comb begin
    locked_d = locked_q;
    if (sync_i)        locked_d = 1'b1;
    else if (misalign) locked_d = 1'b0;
    err_d = err_q;
    if (clear_i)                          err_d = 16'd0;
    else if (misalign && err_q != 16'hFFFF) err_d = err_q + 16'd1;
    ovf_d = clear_i ? 3'd0 : (ovf_q | ovf_set);
  end

  // Lock, error counter, sticky overflow and PPS registers.
  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      locked_q <= 1'b0;
      err_q    <= 16'd0;
      ovf_q    <= 3'd0;
      pps_q    <= 1'b0;
    end else begin
      locked_q <= locked_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      pps_q    <= capture && command_i[30];
    end
  end

  surf_cmd_hold #(.W(10)) u_mode1 (
    .sysclk_i(sysclk_i), .rst_i(rst_i), .load_i(load_m1),
    .data_i  (command_i[27:18]), .tready_i(mode1_tready),
    .tvalid_o(mode1_tvalid), .tdata_o(m1_word), .ovf_o(ovf_set[0])
  );

  surf_cmd_hold #(.W(RUNCMD_BITS)) u_runcmd (
    .sysclk_i(sysclk_i), .rst_i(rst_i), .load_i(load_rc),
    .data_i  (command_i[28 +: RUNCMD_BITS]), .tready_i(runcmd_tready),
    .tvalid_o(runcmd_tvalid), .tdata_o(runcmd_tdata), .ovf_o(ovf_set[1])
  );

  surf_cmd_hold #(.W(TRIG_BITS)) u_trig (
    .sysclk_i(sysclk_i), .rst_i(rst_i), .load_i(load_tr),
    .data_i  (command_i[0 +: TRIG_BITS]), .tready_i(trig_tready),
    .tvalid_o(trig_tvalid), .tdata_o(trig_tdata), .ovf_o(ovf_set[2])
  );

  assign mode1_tuser = m1_word[9:8];
  assign mode1_tdata = m1_word[7:0];
  assign pps_o       = pps_q;
  assign locked_o    = locked_q;
  assign overflow_o  = ovf_q;
  assign err_count_o = err_q;
endmodule

// File: tb/tb_surf_cmd_decode.sv
// Self-checking bench for surf_cmd_decode: directed scenarios followed by
// randomized traffic compared each cycle against a frame-level model.
module tb_surf_cmd_decode;
  logic        sysclk_i = 1'b0;
  logic        rst_i, sync_i, command_valid_i, clear_i;
  logic [31:0] command_i;
  logic        mode1_tready, runcmd_tready, trig_tready;
  logic [7:0]  mode1_tdata;
  logic [1:0]  mode1_tuser;
  logic        mode1_tvalid, runcmd_tvalid, trig_tvalid;
  logic [1:0]  runcmd_tdata;
  logic [14:0] trig_tdata;
  logic        pps_o, locked_o;
  logic [2:0]  overflow_o;
  logic [15:0] err_count_o;

  surf_cmd_decode #(.RUNCMD_BITS(2), .TRIG_BITS(15)) dut (
    .sysclk_i(sysclk_i), .rst_i(rst_i), .sync_i(sync_i),
    .command_i(command_i), .command_valid_i(command_valid_i),
    .mode1_tdata(mode1_tdata), .mode1_tuser(mode1_tuser),
    .mode1_tvalid(mode1_tvalid), .mode1_tready(mode1_tready),
    .runcmd_tdata(runcmd_tdata), .runcmd_tvalid(runcmd_tvalid),
    .runcmd_tready(runcmd_tready),
    .trig_tdata(trig_tdata), .trig_tvalid(trig_tvalid), .trig_tready(trig_tready),
    .pps_o(pps_o), .locked_o(locked_o), .overflow_o(overflow_o),
    .err_count_o(err_count_o), .clear_i(clear_i)
  );

  always #5 sysclk_i = ~sysclk_i;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase derived from cycle count since last sync,
  // each stream a queue holding at most one item.
  int          cyc = 0, base = 0;
  bit          m_locked;
  bit [15:0]   m_err;
  bit [2:0]    m_ovf;
  bit          m_pps;
  logic [9:0]  m1q[$];
  logic [1:0]  rcq[$];
  logic [14:0] trq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cur_phase();
    return (cyc - base) & 7;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_err = 0; m_ovf = 0; m_pps = 0;
    m1q.delete(); rcq.delete(); trq.delete();
  endtask

  // One clock edge of the reference model, using the inputs seen at that edge.
  task automatic model_edge();
    int ph;
    bit mis, cap, ign;
    bit [2:0] set;
    ph  = sync_i ? 0 : cur_phase();
    mis = command_valid_i && ph != 7;
    cap = command_valid_i && ph == 7 && m_locked;
    ign = command_i[31];
    set = 3'b000;
    if (m1q.size() != 0 && mode1_tready)  void'(m1q.pop_front());
    if (rcq.size() != 0 && runcmd_tready) void'(rcq.pop_front());
    if (trq.size() != 0 && trig_tready)   void'(trq.pop_front());
    if (cap && !ign) begin
      if (command_i[27:18] != 0) begin
        if (m1q.size() == 0) m1q.push_back(command_i[27:18]); else set[0] = 1;
      end
      if (command_i[29:28] != 0) begin
        if (rcq.size() == 0) rcq.push_back(command_i[29:28]); else set[1] = 1;
      end
      if (command_i[15]) begin
        if (trq.size() == 0) trq.push_back(command_i[14:0]); else set[2] = 1;
      end
    end
    m_pps = cap && command_i[30];
    if (sync_i) m_locked = 1; else if (mis) m_locked = 0;
    if (clear_i) begin
      m_err = 0; m_ovf = 0;
    end else begin
      if (mis && m_err != 16'hFFFF) m_err++;
      m_ovf |= set;
    end
    if (sync_i) base = cyc;
    cyc++;
  endtask

  task automatic compare_all();
    chk("mode1_tvalid", mode1_tvalid, m1q.size() != 0);
    if (m1q.size() != 0) chk("mode1_word", {mode1_tuser, mode1_tdata}, m1q[0]);
    chk("runcmd_tvalid", runcmd_tvalid, rcq.size() != 0);
    if (rcq.size() != 0) chk("runcmd_tdata", runcmd_tdata, rcq[0]);
    chk("trig_tvalid", trig_tvalid, trq.size() != 0);
    if (trq.size() != 0) chk("trig_tdata", trig_tdata, trq[0]);
    chk("pps", pps_o, m_pps);
    chk("locked", locked_o, m_locked);
    chk("overflow", overflow_o, m_ovf);
    chk("err_count", err_count_o, m_err);
  endtask

  task automatic step();
    @(posedge sysclk_i);
    if (!rst_i) model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    sync_i = 0; command_valid_i = 0; clear_i = 0; command_i = 32'h0;
  endtask

  task automatic do_sync();
    idle(); sync_i = 1; step(); sync_i = 0;
  endtask

  task automatic wait_phase(input int p);
    idle();
    for (int i = 0; i < 8 && cur_phase() != p; i++) step();
  endtask

  task automatic send_word(input logic [31:0] w);
    wait_phase(7);
    command_i = w; command_valid_i = 1; step(); idle();
  endtask

  task automatic do_reset();
    rst_i = 1; idle(); model_reset();
    repeat (2) @(posedge sysclk_i);
    @(negedge sysclk_i); rst_i = 0;
    base = cyc;
  endtask

  initial begin
    rst_i = 1; idle();
    mode1_tready = 1; runcmd_tready = 1; trig_tready = 1;
    model_reset();
    #12;
    chk("rst_mode1_tvalid", mode1_tvalid, 0);
    chk("rst_mode1_data", {mode1_tuser, mode1_tdata}, 0);
    chk("rst_trig_tdata", trig_tdata, 0);
    chk("rst_runcmd_tdata", runcmd_tdata, 0);
    compare_all();
    do_reset();
    // A phase-7 word before any sync is dropped silently.
    send_word(32'h0000_8077);
    chk("unlocked_drop", trig_tvalid, 0);

    // Basic decode with streams stalled so the outputs can be inspected.
    mode1_tready = 0; runcmd_tready = 0; trig_tready = 0;
    do_sync();
    send_word(32'h4A4A_8123);
    chk("t1_pps", pps_o, 1);
    chk("t1_runcmd_none", runcmd_tvalid, 0);
    chk("t1_mode1_v", mode1_tvalid, 1);
    chk("t1_mode1_type", mode1_tuser, 2'b10);
    chk("t1_mode1_data", mode1_tdata, 8'h92);
    chk("t1_trig", trig_tdata, 15'h0123);
    chk("t1_trig_v", trig_tvalid, 1);
    step();
    chk("t1_pps_one_cycle", pps_o, 0);
    mode1_tready = 1; runcmd_tready = 1; trig_tready = 1;
    step();
    chk("t1_drained", {mode1_tvalid, trig_tvalid}, 0);

    // Ignore bit with pps: pulse only.
    send_word(32'hC000_0000);
    chk("t2_pps", pps_o, 1);
    chk("t2_no_streams", {mode1_tvalid, runcmd_tvalid, trig_tvalid}, 0);

    // Back-to-back trig with no ready: second word overflows.
    trig_tready = 0;
    send_word(32'h0000_8001);
    send_word(32'h0000_8002);
    step();
    chk("t3_trig_held", trig_tdata, 15'h0001);
    chk("t3_ovf", overflow_o[2], 1);
    clear_i = 1; step(); clear_i = 0;
    chk("t3_ovf_cleared", overflow_o, 0);
    trig_tready = 1; step(); trig_tready = 0;

    // Handshake in the capture cycle frees the slot.
    send_word(32'h0000_8001);
    wait_phase(7);
    command_i = 32'h0000_8002; command_valid_i = 1; trig_tready = 1;
    step(); idle(); trig_tready = 0;
    chk("t4_trig_new", trig_tdata, 15'h0002);
    chk("t4_no_ovf", overflow_o, 0);
    trig_tready = 1; step();

    // Misaligned strobe drops lock, later words ignored until sync.
    do_sync();
    wait_phase(3);
    command_i = 32'h0000_8009; command_valid_i = 1; step(); idle();
    chk("t5_unlocked", locked_o, 0);
    chk("t5_err1", err_count_o, 1);
    send_word(32'h4000_8005);
    chk("t5_ignored", {pps_o, trig_tvalid}, 0);
    clear_i = 1; step(); clear_i = 0;
    chk("t5_err_clear", err_count_o, 0);
    // Sync with a same-cycle strobe: sync wins, error still counted.
    sync_i = 1; command_valid_i = 1; step(); idle();
    chk("t5_sync_wins", locked_o, 1);
    chk("t5_sync_err", err_count_o, 1);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      sync_i          = ($urandom_range(0, 39) == 0);
      command_valid_i = (cur_phase() == 7 && !sync_i) ? ($urandom_range(0, 3) != 0)
                                                      : ($urandom_range(0, 59) == 0);
      command_i       = $urandom;
      if ($urandom_range(0, 1) == 0) command_i[27:18] = 10'd0;
      clear_i         = ($urandom_range(0, 59) == 0);
      mode1_tready    = $urandom_range(0, 1);
      runcmd_tready   = $urandom_range(0, 1);
      trig_tready     = $urandom_range(0, 2) == 0;
      step();
    end
    idle();

    // Asynchronous reset while a mode1 word is held.
    mode1_tready = 0;
    do_sync();
    send_word(32'h0C40_0000);
    chk("t6_mode1_held", mode1_tvalid, 1);
    #2 rst_i = 1; #1;
    chk("t6_async_v", {mode1_tvalid, runcmd_tvalid, trig_tvalid}, 0);
    chk("t6_async_data", {mode1_tuser, mode1_tdata}, 0);
    chk("t6_async_misc", {pps_o, locked_o, overflow_o, err_count_o}, 0);
    do_reset();
    mode1_tready = 1;
    step();
    chk("t6_locked_after", locked_o, 0);
    send_word(32'h0C40_0000);
    chk("t6_no_decode", mode1_tvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
